// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: FSM states,
// key-word layout, prefix bytes and the device-response discard list.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned KEY_W       = 11;
  localparam int unsigned KEY_TOGGLE  = 10;
  localparam int unsigned KEY_PRESSED = 9;
  localparam int unsigned KEY_EXT     = 8;
  localparam int unsigned CODE_W      = 8;

  localparam logic [CODE_W-1:0] PFX_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] PFX_REL   = 8'hF0;
  localparam logic [CODE_W-1:0] PFX_PAUSE = 8'hE1;

  // Bytes that follow E1 in the Pause make/break sequence
  localparam int unsigned PAUSE_SKIP = 7;

  localparam int unsigned N_DISCARD = 7;
  localparam logic [N_DISCARD-1:0][CODE_W-1:0] DISCARD_CODES = {
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF
  };

  function automatic logic is_discard(input logic [CODE_W-1:0] code);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_DISCARD; i++) begin
      if (code == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus deglitch filter for one raw PS/2 line.
// The filtered output flips only after FILTER_LEN consecutive opposite samples.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_raw,
  output logic line_filt
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Run length of the level opposite to the current output
  always_comb begin
    sync_d = {sync_q[0], line_raw};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes off the filtered lines, checks parity,
// stop bit and inter-edge timeout, then folds prefixes into key event words.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [KEY_W-1:0]  ps2_key,
  output logic [CODE_W-1:0] rx_byte,
  output logic              rx_strobe,
  output logic              rx_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic clk_f, data_f, fall_c;
  logic frame_ok_c, frame_err_c;

  ps2_state_e        state_q, state_d;
  logic              clk_prev_q, clk_prev_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ext_q, ext_d;
  logic              rel_q, rel_d;
  logic [2:0]        skip_q, skip_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [CODE_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_strobe_q, rx_strobe_d;
  logic              rx_err_q, rx_err_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .line_raw  (ps2_clk),
    .line_filt (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .line_raw  (ps2_data),
    .line_filt (data_f)
  );

  assign fall_c = clk_prev_q & ~clk_f;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      key_q       <= '0;
      rx_byte_q   <= '0;
      rx_strobe_q <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      rx_err_q    <= rx_err_d;
    end
  end

  // Frame FSM and inter-edge timeout
  always_comb begin
    state_d     = state_q;
    clk_prev_d  = clk_f;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    frame_ok_c  = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall_c && !data_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shift_d   = {data_f, shift_q[CODE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_c) begin
          par_d   = data_f;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_c) begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && data_f) frame_ok_c  = 1'b1;
          else                               frame_err_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (fall_c) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        to_cnt_d    = '0;
        state_d     = IDLE;
        frame_err_c = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // Byte classification: errors flush all prefix state
  always_comb begin
    ext_d       = ext_q;
    rel_d       = rel_q;
    skip_d      = skip_q;
    key_d       = key_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    rx_err_d    = 1'b0;

    if (frame_err_c) begin
      rx_err_d = 1'b1;
      ext_d    = 1'b0;
      rel_d    = 1'b0;
      skip_d   = '0;
    end else if (frame_ok_c) begin
      rx_strobe_d = 1'b1;
      rx_byte_d   = shift_q;
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (shift_q == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PFX_REL) begin
        rel_d = 1'b1;
      end else if (shift_q == PFX_PAUSE) begin
        skip_d = 3'(PAUSE_SKIP);
      end else if (!ext_q && !rel_q && is_discard(shift_q)) begin
        skip_d = skip_q;
      end else begin
        key_d[KEY_TOGGLE]    = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED]   = ~rel_q;
        key_d[KEY_EXT]       = ext_q;
        key_d[CODE_W-1:0]    = shift_q;
        ext_d                = 1'b0;
        rel_d                = 1'b0;
      end
    end
  end

  assign ps2_key   = key_q;
  assign rx_byte   = rx_byte_q;
  assign rx_strobe = rx_strobe_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with
// hand-computed key words, pulse counts and error cases.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TOUT = 200;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        rx_err;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int key_chg    = 0;
  logic [10:0] key_prev = '0;

  ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (rx_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (rx_strobe) strobe_cnt++;
    if (rx_err) err_cnt++;
    if (rx_strobe && rx_err) both_cnt++;
    if (ps2_key != key_prev) key_chg++;
    key_prev = ps2_key;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set during high phase, sampled on the falling edge
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      tick(4); ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; tick(5);
    end else begin
      tick(10);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      tick(4); ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0; tick(5);
    end else begin
      tick(10);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip,
                            input logic stop_val, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
    send_bit((~^code) ^ par_flip, glitch);
    send_bit(stop_val, glitch);
    ps2_data = 1'b1;
    tick(30);
  endtask

  initial begin
    int s0;
    int k0;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_key",    32'(ps2_key),   32'h000);
    check("reset_byte",   32'(rx_byte),   32'h00);
    check("reset_strobe", 32'(rx_strobe), 32'd0);
    check("reset_err",    32'(rx_err),    32'd0);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("1c_byte",   32'(rx_byte),  32'h1C);
    check("1c_strobe", 32'(strobe_cnt), 32'd1);
    check("1c_key",    32'(ps2_key),  32'h61C);

    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    check("e0_key", 32'(ps2_key), 32'h61C);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("f0_key", 32'(ps2_key), 32'h61C);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("75_key",    32'(ps2_key),    32'h175);
    check("75_strobe", 32'(strobe_cnt), 32'd4);

    send_frame(8'h29, 1'b1, 1'b1, 1'b0);
    check("badpar_err",    32'(err_cnt),    32'd1);
    check("badpar_strobe", 32'(strobe_cnt), 32'd4);
    check("badpar_key",    32'(ps2_key),    32'h175);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("29_key", 32'(ps2_key), 32'h629);

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(TOUT / 2);
    check("to_early_err", 32'(err_cnt), 32'd1);
    tick(TOUT);
    check("to_err",   32'(err_cnt), 32'd2);
    check("to_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    check("05_key", 32'(ps2_key), 32'h205);

    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    check("badstop_err", 32'(err_cnt), 32'd3);
    check("badstop_key", 32'(ps2_key), 32'h205);

    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("extclr_err", 32'(err_cnt), 32'd4);
    check("extclr_key", 32'(ps2_key), 32'h61C);

    s0 = strobe_cnt;
    send_frame(8'h6B, 1'b0, 1'b1, 1'b1);
    check("glitch_byte",   32'(rx_byte),        32'h6B);
    check("glitch_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("glitch_key",    32'(ps2_key),        32'h26B);
    check("glitch_err",    32'(err_cnt),        32'd4);

    s0 = strobe_cnt;
    k0 = key_chg;
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b1, 1'b0);
    check("pause_strobe", 32'(strobe_cnt - s0), 32'd8);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    check("aa_strobe", 32'(strobe_cnt - s0), 32'd9);
    check("aa_byte",   32'(rx_byte),         32'hAA);
    check("pause_key", 32'(ps2_key),         32'h26B);
    check("pause_chg", 32'(key_chg - k0),    32'd0);

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(TOUT + 20);
    check("rst_key",   32'(ps2_key),      32'h000);
    check("rst_err",   32'(err_cnt),      32'd4);
    check("rst_state", 32'(dut.state_q),  32'(IDLE));
    check("no_both",   32'(both_cnt),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
